// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Definitions shared between the ALU control decoder and the EX-stage
// multiply / multiply-accumulate unit.
//   - 4-bit ALU operation codes (MUL_OP = 8, MAC_OP = 9)
//   - state encoding for the iterative multiplier sequencer
//   - is_mul_op(): true for the opcodes handled by mul_mac_unit
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam logic [3:0] AND_OP = 4'd0;
  localparam logic [3:0] OR_OP  = 4'd1;
  localparam logic [3:0] ADD_OP = 4'd2;
  localparam logic [3:0] SUB_OP = 4'd3;
  localparam logic [3:0] XOR_OP = 4'd4;
  localparam logic [3:0] SLT_OP = 4'd5;
  localparam logic [3:0] SLL_OP = 4'd6;
  localparam logic [3:0] SRL_OP = 4'd7;
  localparam logic [3:0] MUL_OP = 4'd8;
  localparam logic [3:0] MAC_OP = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mac_state_e;

  function automatic logic is_mul_op(input logic [3:0] ctrl);
    return (ctrl == MUL_OP) || (ctrl == MAC_OP);
  endfunction

endpackage

// File: rtl/mult_chunk.sv
// ---------------------------------------------------------------------------
// mult_chunk
// Combinational DATA_W x CHUNK_W partial-product generator. Multiplies the
// multiplicand by one CHUNK_W-bit slice of the multiplier, shifts the
// product into position and keeps only the low DATA_W bits.
// Ports:
//   a       in  DATA_W   multiplicand
//   b_chunk in  CHUNK_W  multiplier slice
//   shamt   in  SH_W     left shift applied to the product (slice position)
//   term    out DATA_W   truncated, shifted partial product
// ---------------------------------------------------------------------------
module mult_chunk #(
  parameter int DATA_W  = 32,
  parameter int CHUNK_W = 8,
  parameter int SH_W    = $clog2(DATA_W)
) (
  input  logic [DATA_W-1:0]  a,
  input  logic [CHUNK_W-1:0] b_chunk,
  input  logic [SH_W-1:0]    shamt,
  output logic [DATA_W-1:0]  term
);

  // One shifted copy of the multiplicand per multiplier bit; bits of the
  // product above DATA_W never reach the result, so rows are truncated early.
  logic [DATA_W-1:0] rows [CHUNK_W];
  logic [DATA_W-1:0] prod;

  genvar gi;
  generate
    for (gi = 0; gi < CHUNK_W; gi++) begin : g_row
      assign rows[gi] = b_chunk[gi] ? (a << gi) : '0;
    end
  endgenerate

  always_comb begin
    prod = '0;
    for (int i = 0; i < CHUNK_W; i++) begin
      prod = prod + rows[i];
    end
    term = prod << shamt;
  end

endmodule

// File: rtl/mul_mac_unit.sv
// ---------------------------------------------------------------------------
// mul_mac_unit
// Multi-cycle MUL / MAC execution unit for the EX stage. The multiplier is
// consumed CHUNK_W bits per cycle (DATA_W/CHUNK_W cycles), the product is
// kept modulo 2^DATA_W, and MAC adds it into a private accumulator.
// Ports:
//   clk          in   clock, all state on rising edge
//   arst_n       in   asynchronous active-low reset
//   op_valid     in   EX-stage instruction valid
//   alu_control  in   decoded ALU op (MUL_OP / MAC_OP handled here)
//   mac_select   in   high for MAC, must agree with alu_control == MAC_OP
//   operand_a    in   multiplicand (rs1)
//   operand_b    in   multiplier (rs2)
//   acc_clr      in   zero the accumulator, honoured only while idle
//   flush        in   abort the current operation
//   stall        out  combinational pipeline freeze while busy
//   done         out  one-cycle pulse, result valid
//   result       out  MUL product or new accumulator value
//   acc          out  current accumulator value
// ---------------------------------------------------------------------------
module mul_mac_unit
  import alu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int CHUNK_W = 8
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              op_valid,
  input  logic [3:0]        alu_control,
  input  logic              mac_select,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  input  logic              acc_clr,
  input  logic              flush,
  output logic              stall,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] acc
);

  localparam int CYCLES = DATA_W / CHUNK_W;
  localparam int CNT_W  = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam int SH_W   = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

  mac_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              is_mac_q, is_mac_d;
  logic [DATA_W-1:0] partial_q, partial_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              done_q, done_d;

  logic              start;
  logic [CHUNK_W-1:0] b_chunk;
  logic [SH_W-1:0]   shamt;
  logic [DATA_W-1:0] term;
  logic [DATA_W-1:0] partial_sum;
  logic [DATA_W-1:0] acc_sum;

  // Gating with arst_n keeps stall low while reset is held, so every
  // output reads zero as soon as reset is asserted.
  assign start = arst_n && op_valid && is_mul_op(alu_control) && !flush
                 && (state_q == IDLE);

  assign stall = start || (state_q == CALC);

  assign b_chunk = b_q[int'(cnt_q) * CHUNK_W +: CHUNK_W];
  assign shamt   = SH_W'(int'(cnt_q) * CHUNK_W);

  mult_chunk #(
    .DATA_W (DATA_W),
    .CHUNK_W(CHUNK_W),
    .SH_W   (SH_W)
  ) u_mult_chunk (
    .a      (a_q),
    .b_chunk(b_chunk),
    .shamt  (shamt),
    .term   (term)
  );

  assign partial_sum = partial_q + term;
  assign acc_sum     = acc_q + partial_sum;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    is_mac_d  = is_mac_q;
    partial_d = partial_q;
    acc_d     = acc_q;
    result_d  = result_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d       = operand_a;
          b_d       = operand_b;
          is_mac_d  = mac_select;
          partial_d = '0;
          cnt_d     = '0;
          state_d   = CALC;
        end else if (acc_clr) begin
          acc_d = '0;
        end
      end

      CALC: begin
        if (flush) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          partial_d = partial_sum;
          if (cnt_q == CNT_LAST) begin
            // Final chunk: the result and accumulator are registered on the
            // way into DONE so both are already valid while done is high.
            cnt_d    = '0;
            state_d  = DONE;
            done_d   = 1'b1;
            result_d = is_mac_q ? acc_sum : partial_sum;
            if (is_mac_q) begin
              acc_d = acc_sum;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      // The held instruction retires here; start is not evaluated, and a
      // flush arriving now cannot undo the completed operation.
      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      is_mac_q  <= 1'b0;
      partial_q <= '0;
      acc_q     <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      is_mac_q  <= is_mac_d;
      partial_q <= partial_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
      done_q    <= done_d;
    end
  end

  assign done   = done_q;
  assign result = result_q;
  assign acc    = acc_q;

  // mac_select is a redundant copy of the MAC decode; disagreement means the
  // decoder upstream is broken.
  a_mac_select_consistent : assert property (
    @(posedge clk) disable iff (!arst_n)
    op_valid |-> (mac_select == (alu_control == MAC_OP))
  );

endmodule

// File: tb/tb_mul_mac_unit.sv
module tb_mul_mac_unit;
  import alu_pkg::*;

  logic        clk;
  logic        arst_n;
  logic        op_valid;
  logic [3:0]  alu_control;
  logic        mac_select;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        acc_clr;
  logic        flush;
  logic        stall;
  logic        done;
  logic [31:0] result;
  logic [31:0] acc;

  mul_mac_unit #(.DATA_W(32), .CHUNK_W(8)) dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .op_valid   (op_valid),
    .alu_control(alu_control),
    .mac_select (mac_select),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .acc_clr    (acc_clr),
    .flush      (flush),
    .stall      (stall),
    .done       (done),
    .result     (result),
    .acc        (acc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_txn    = 0;

  typedef struct {
    logic [31:0] res;
    logic [31:0] acc;
  } exp_t;
  exp_t sb_q[$];

  // clr_mode: 0 none, 1 acc_clr pulse in idle before the op,
  // 2 acc_clr held through the whole op (start wins, ignored in CALC/DONE)
  typedef struct {
    logic [3:0]  ctrl;
    logic        ms;
    logic [31:0] a;
    logic [31:0] b;
    int          clr_mode;
    logic [31:0] exp_res;
    logic [31:0] exp_acc;
  } vec_t;
  vec_t vecs[10];

  typedef struct {
    logic [3:0] ctrl;
    logic       valid;
    logic       fl;
  } nostart_t;
  nostart_t ns[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Scoreboard: every done pulse pops the oldest expected result.
  always @(negedge clk) begin
    if (arst_n && done) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        n_txn++;
        $display("txn %0d: result=0x%08h (exp 0x%08h) acc=0x%08h (exp 0x%08h)",
                 n_txn, result, e.res, acc, e.acc);
        chk($sformatf("txn%0d_result", n_txn), result, e.res);
        chk($sformatf("txn%0d_acc", n_txn), acc, e.acc);
      end
    end
  end

  // Called #1 after a rising edge; returns #2 after a rising edge, idle.
  task automatic issue(input logic [3:0] ctrl, input logic ms, input logic [31:0] a,
                       input logic [31:0] b, input int clr_mode,
                       input logic [31:0] er, input logic [31:0] ea, input string tag);
    exp_t e;
    if (clr_mode == 1) begin
      acc_clr = 1'b1;
      @(posedge clk); #1;
      acc_clr = 1'b0;
      chk({tag, "_acc_clr"}, acc, 32'd0);
    end
    op_valid    = 1'b1;
    alu_control = ctrl;
    mac_select  = ms;
    operand_a   = a;
    operand_b   = b;
    acc_clr     = (clr_mode == 2);
    e.res = er;
    e.acc = ea;
    sb_q.push_back(e);
    #1 chk({tag, "_stall_c0"}, 32'(stall), 32'd1);
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      operand_a = $urandom;
      operand_b = $urandom;
      #1;
      chk($sformatf("%s_stall_c%0d", tag, c), 32'(stall), 32'd1);
      chk($sformatf("%s_done_c%0d", tag, c), 32'(done), 32'd0);
    end
    @(posedge clk); #1;
    chk({tag, "_stall_c5"}, 32'(stall), 32'd0);
    chk({tag, "_done_c5"}, 32'(done), 32'd1);
    @(posedge clk); #1;
    op_valid = 1'b0;
    acc_clr  = 1'b0;
    #1 chk({tag, "_done_c6"}, 32'(done), 32'd0);
  endtask

  initial begin
    vecs[0] = '{MUL_OP, 1'b0, 32'd3,          32'd5,          0, 32'd15,         32'd0};
    vecs[1] = '{MUL_OP, 1'b0, 32'hFFFFFFFF,   32'd2,          0, 32'hFFFFFFFE,   32'd0};
    vecs[2] = '{MUL_OP, 1'b0, 32'h12345678,   32'h9ABCDEF0,   0, 32'h242D2080,   32'd0};
    vecs[3] = '{MAC_OP, 1'b1, 32'h10,         32'h10,         0, 32'd256,        32'd256};
    vecs[4] = '{MAC_OP, 1'b1, 32'd2,          32'd3,          1, 32'd6,          32'd6};
    vecs[5] = '{MAC_OP, 1'b1, 32'd4,          32'd5,          2, 32'd26,         32'd26};
    vecs[6] = '{MAC_OP, 1'b1, 32'h80000000,   32'd2,          0, 32'd26,         32'd26};
    vecs[7] = '{MUL_OP, 1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   0, 32'd1,          32'd26};
    vecs[8] = '{MAC_OP, 1'b1, 32'hFFFFFFFF,   32'd1,          0, 32'd25,         32'd25};
    vecs[9] = '{MAC_OP, 1'b1, 32'h00010001,   32'h00030005,   0, 32'h0008001E,   32'h0008001E};

    ns[0] = '{ADD_OP, 1'b1, 1'b0};
    ns[1] = '{MUL_OP, 1'b0, 1'b0};
    ns[2] = '{MUL_OP, 1'b1, 1'b1};

    arst_n = 1'b0; op_valid = 1'b0; alu_control = ADD_OP; mac_select = 1'b0;
    operand_a = '0; operand_b = '0; acc_clr = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_acc", acc, 32'd0);
    @(negedge clk) arst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].ctrl, vecs[i].ms, vecs[i].a, vecs[i].b, vecs[i].clr_mode,
            vecs[i].exp_res, vecs[i].exp_acc, $sformatf("v%0d", i));
    end

    // Flush in CALC cycle 2 of MAC 7*7 with acc = 10.
    issue(MAC_OP, 1'b1, 32'd2, 32'd5, 1, 32'd10, 32'd10, "pre_flush");
    op_valid = 1'b1; alu_control = MAC_OP; mac_select = 1'b1;
    operand_a = 32'd7; operand_b = 32'd7;
    #1 chk("fl_stall_c0", 32'(stall), 32'd1);
    @(posedge clk); #1;
    chk("fl_stall_c1", 32'(stall), 32'd1);
    @(posedge clk); #1;
    flush = 1'b1;
    #1 chk("fl_stall_c2", 32'(stall), 32'd1);
    @(posedge clk); #1;
    flush = 1'b0; op_valid = 1'b0;
    #1;
    chk("fl_stall_c3", 32'(stall), 32'd0);
    for (int c = 4; c < 9; c++) begin
      @(posedge clk); #1;
      chk($sformatf("fl_done_c%0d", c), 32'(done), 32'd0);
    end
    chk("fl_acc", acc, 32'd10);
    chk("fl_result", result, 32'd10);
    issue(MUL_OP, 1'b0, 32'd1, 32'd1, 0, 32'd1, 32'd10, "post_flush");

    // Reset asserted in cycle 3 of a MAC.
    op_valid = 1'b1; alu_control = MAC_OP; mac_select = 1'b1;
    operand_a = 32'd3; operand_b = 32'd3;
    repeat (3) begin @(posedge clk); #1; end
    arst_n = 1'b0; op_valid = 1'b0;
    #1;
    chk("rst_mid_stall", 32'(stall), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    chk("rst_mid_result", result, 32'd0);
    chk("rst_mid_acc", acc, 32'd0);
    @(negedge clk);
    @(negedge clk) arst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      chk($sformatf("rst_after_done_%0d", c), 32'(done), 32'd0);
      chk($sformatf("rst_after_stall_%0d", c), 32'(stall), 32'd0);
    end

    // Inputs that must not start an operation.
    for (int k = 0; k < 3; k++) begin
      op_valid = ns[k].valid; alu_control = ns[k].ctrl; mac_select = 1'b0;
      flush = ns[k].fl; operand_a = 32'd9; operand_b = 32'd9;
      for (int c = 0; c < 6; c++) begin
        #1;
        chk($sformatf("ns%0d_stall_c%0d", k, c), 32'(stall), 32'd0);
        chk($sformatf("ns%0d_done_c%0d", k, c), 32'(done), 32'd0);
        @(posedge clk); #1;
      end
      op_valid = 1'b0; flush = 1'b0;
    end

    repeat (3) @(posedge clk);
    #1 chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mul_mac_unit.md
Name: mul_mac_unit

Overview:
- Multi-cycle multiply / multiply-accumulate execution unit in the EX stage.
- Sits directly downstream of the ALU control decoder and consumes its `alu_control` (MUL_OP=8, MAC_OP=9) and `mac_select` outputs.
- Computes MUL in CYCLES clock cycles by iterative shift-add. Holds a private accumulator for MAC.
- Raises `stall` to freeze the pipeline while busy, and presents `result` with a one-cycle `done` pulse.

Parameters:
- DATA_W, 32, operand/result/accumulator width.
- CHUNK_W, 8, multiplier bits consumed per cycle; DATA_W must be a multiple of CHUNK_W.
- CYCLES, DATA_W/CHUNK_W (=4), derived; not overridable.

Ports:
- clk  in  1  Single clock; all state on rising edge.
- arst_n  in  1  Asynchronous active-low reset.
- op_valid  in  1  EX-stage instruction valid (not a bubble).
- alu_control  in  4  Decoded ALU op; 8=MUL, 9=MAC, others ignored.
- mac_select  in  1  High for MAC; must agree with alu_control==9.
- operand_a  in  DATA_W  rs1 value (multiplicand).
- operand_b  in  DATA_W  rs2 value (multiplier).
- acc_clr  in  1  Zero the accumulator; honoured only in IDLE.
- flush  in  1  Abort current operation (branch mispredict).
- stall  out  1  Combinational; freezes PC/IF/ID/EX registers.
- done  out  1  Registered; result valid this cycle.
- result  out  DATA_W  Registered; MUL product or new accumulator value.
- acc  out  DATA_W  Current accumulator value, for debug.

Behaviour:
- Reset (async, arst_n=0): state=IDLE, cnt=0, partial=0, acc=0, result=0, done=0.
- start = op_valid & (alu_control==MUL_OP | alu_control==MAC_OP), qualified by state==IDLE.
- States and transitions:
  - IDLE: on start, capture a, b, is_mac=mac_select, set partial=0, cnt=0, go to CALC.
  - IDLE: else, if acc_clr, set acc=0.
  - CALC: partial += (a_cap * b_cap[cnt*CHUNK_W +: CHUNK_W]) << (cnt*CHUNK_W), truncated to DATA_W; cnt++. After cnt==CYCLES-1, go to DONE.
  - DONE: done=1. result = is_mac ? acc+partial : partial. If is_mac, acc <= acc+partial. Always go to IDLE next. start is ignored in DONE, so the held instruction is not relaunched.
- Timing:
  - Cycle 0: start seen.
  - Cycles 1..CYCLES: CALC.
  - Cycle CYCLES+1: done=1 (cycle 5 by default).
- stall = (state==IDLE & start) | (state==CALC). stall is low in DONE so the instruction retires that cycle.
- Arithmetic:
  - Only the low DATA_W bits are kept; this result is identical for signed and unsigned operands.
  - The accumulator wraps modulo 2^DATA_W.
- Inputs operand_a/b may change after the start cycle. Captured copies are used.
- acc_clr is ignored in CALC/DONE.
- If start and acc_clr coincide in IDLE, start wins and acc_clr is dropped.
- flush:
  - In CALC: return to IDLE next cycle. No done, acc unchanged, result unchanged.
  - In IDLE: suppresses start.
  - In DONE: ignored; completion stands.
- mac_select=1 with alu_control!=9, or the reverse, is illegal; the assertion fires in simulation.
- done stays high exactly one cycle. result holds its value until the next DONE.
- A reset asserted mid-operation forces IDLE immediately and clears acc.

Decomposition:
- Shared package `alu_pkg`:
  - ALU op codes (AND_OP..MUL_OP=4'd8, MAC_OP=4'd9), shared with the ALU control decoder.
  - State enum {IDLE, CALC, DONE}.
- One sub-module, `mult_chunk`: a combinational DATA_W x CHUNK_W partial-product generator that takes the shift amount and returns a DATA_W-truncated term.

Test Plan:
- MUL a=3, b=5, op_valid=1, alu_control=8 -> stall high cycles 0-4; done=1 in cycle 5 with result=15; acc stays 0.
- MUL a=0xFFFFFFFF, b=2 -> result=0xFFFFFFFE. MUL a=0x12345678, b=0x9ABCDEF0 -> result=0x242D2080, low 32 bits of the product.
- acc_clr in IDLE, then MAC 2*3, then MAC 4*5 -> result=6 then 26, acc=26. A third MAC 0x80000000*2 -> result=26, acc=26 (the product wraps to 0).
- flush in cycle 2 of MAC 7*7 with acc=10 -> no done, stall low from cycle 3, acc=10, result unchanged. Next MUL 1*1 -> result=1 at the normal latency.
- arst_n pulsed low in cycle 3 of MAC -> all outputs 0 immediately. After release, no done occurs without a new start.
- alu_control=2 (ADD) with op_valid=1 -> stall=0, done never asserted. op_valid=0 with alu_control=8 -> no start.
